// File: rtl/gpio_if_pkg.sv
// Shared definitions for the GPIO ingress unpacker and the matching egress packer.
// Both directions use the same state encoding and word/sample ordering.
package gpio_if_pkg;

    localparam logic [2:0] ST_IDLE   = 3'b001;
    localparam logic [2:0] ST_LOAD   = 3'b010;
    localparam logic [2:0] ST_STREAM = 3'b100;

    localparam int SAMPLES_PER_WORD    = 3;
    localparam int DEF_BATCH_NUM       = 42;
    localparam int DEF_NPU_INPUT_WIDTH = 16;
    localparam int DEF_INPUT_WIDTH     = DEF_NPU_INPUT_WIDTH * SAMPLES_PER_WORD;
    localparam int DEF_FIFO_WIDTH      = DEF_INPUT_WIDTH;
    localparam int DEF_FIFO_DEPTH      = 16;

    function automatic int words_for(input int batch_num);
        return batch_num / SAMPLES_PER_WORD;
    endfunction

    localparam int WORDS_PER_BATCH = words_for(DEF_BATCH_NUM);

endpackage

// File: rtl/gpio_input_interface_sync_fifo.sv
// Single-clock FIFO with registered read data and a one-cycle read-valid flag.
// Writes while full and reads while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_en,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_wr_s;
    logic             do_rd_s;

    assign full    = (count_r == CW'(DEPTH));
    assign empty   = (count_r == {CW{1'b0}});
    assign do_wr_s = wr_en & ~full;
    assign do_rd_s = rd_en & ~empty;

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            rd_data  <= {WIDTH{1'b0}};
            valid    <= 1'b0;
        end else begin
            valid <= do_rd_s;
            if (do_wr_s) begin
                wr_ptr_r <= (wr_ptr_r == AW'(DEPTH - 1)) ? {AW{1'b0}} : wr_ptr_r + AW'(1);
            end
            if (do_rd_s) begin
                rd_data  <= mem_r[rd_ptr_r];
                rd_ptr_r <= (rd_ptr_r == AW'(DEPTH - 1)) ? {AW{1'b0}} : rd_ptr_r + AW'(1);
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/gpio_input_interface.sv
// Host-to-NPU ingress: buffers one batch of 48-bit host words, then streams
// each word MSB-first as three 16-bit samples over a valid/ready handshake.
module gpio_input_interface
    import gpio_if_pkg::*;
#(
    parameter int BATCH_NUM       = DEF_BATCH_NUM,
    parameter int NPU_INPUT_WIDTH = DEF_NPU_INPUT_WIDTH,
    parameter int INPUT_WIDTH     = DEF_INPUT_WIDTH,
    parameter int FIFO_WIDTH      = DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
    input  logic                       sys_clk,
    input  logic                       rst_n,
    input  logic                       host_wr_en,
    input  logic [INPUT_WIDTH-1:0]     host_wr_data,
    output logic                       host_busy,
    output logic                       wr_err,
    output logic                       cal_start,
    output logic [NPU_INPUT_WIDTH-1:0] npu_in_data,
    output logic                       npu_in_data_vld,
    input  logic                       npu_in_ready,
    output logic                       batch_done
);

    localparam int WORDS = words_for(BATCH_NUM);
    localparam int SCW   = $clog2(BATCH_NUM + 1);
    localparam int WCW   = $clog2(WORDS + 1);

    logic [2:0]             state_r;
    logic [2:0]             state_nxt_s;
    logic [WCW-1:0]         word_cnt_r;
    logic [SCW-1:0]         sample_cnt_r;
    logic [INPUT_WIDTH-1:0] shift_r;
    logic [1:0]             idx_r;
    logic                   vld_r;
    logic                   cal_start_r;
    logic                   host_busy_r;
    logic                   wr_err_r;
    logic                   batch_done_r;

    logic                   is_stream_s;
    logic                   wr_accept_s;
    logic                   wr_drop_s;
    logic                   accept_s;
    logic                   last_in_word_s;
    logic                   last_sample_s;
    logic                   batch_full_s;
    logic                   fifo_rd_en_s;
    logic [FIFO_WIDTH-1:0]  fifo_rd_data_s;
    logic                   fifo_valid_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;

    assign is_stream_s    = (state_r == ST_STREAM);
    assign wr_accept_s    = host_wr_en & ~is_stream_s & ~fifo_full_s;
    assign wr_drop_s      = host_wr_en & ~wr_accept_s;
    assign accept_s       = vld_r & npu_in_ready;
    assign last_in_word_s = accept_s & (idx_r == 2'd2);
    assign last_sample_s  = accept_s & (sample_cnt_r == SCW'(BATCH_NUM - 1));
    // word_cnt is 0 in IDLE, so a one-word batch also jumps straight to STREAM.
    assign batch_full_s   = wr_accept_s & (word_cnt_r == WCW'(WORDS - 1));
    // First word is fetched on cal_start; later words are prefetched on the third sample.
    assign fifo_rd_en_s   = (cal_start_r | (last_in_word_s & ~last_sample_s)) & ~fifo_empty_s;

    assign host_busy       = host_busy_r;
    assign wr_err          = wr_err_r;
    assign cal_start       = cal_start_r;
    assign batch_done      = batch_done_r;
    assign npu_in_data_vld = vld_r;
    assign npu_in_data     = shift_r[INPUT_WIDTH-1 -: NPU_INPUT_WIDTH];

    sync_fifo #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) sync_fifo_inst (
        .clk     (sys_clk),
        .rst_n   (rst_n),
        .rd_en   (fifo_rd_en_s),
        .wr_en   (wr_accept_s),
        .wr_data (host_wr_data),
        .rd_data (fifo_rd_data_s),
        .valid   (fifo_valid_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Next-state decode for the load/stream sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (batch_full_s) begin
                    state_nxt_s = ST_STREAM;
                end else if (wr_accept_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (batch_full_s) begin
                    state_nxt_s = ST_STREAM;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_STREAM: begin
                if (last_sample_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, counters and registered status pulses.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            word_cnt_r   <= {WCW{1'b0}};
            sample_cnt_r <= {SCW{1'b0}};
            cal_start_r  <= 1'b0;
            host_busy_r  <= 1'b0;
            wr_err_r     <= 1'b0;
            batch_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cal_start_r  <= ~is_stream_s & (state_nxt_s == ST_STREAM);
            host_busy_r  <= (state_nxt_s == ST_STREAM);
            wr_err_r     <= wr_drop_s;
            batch_done_r <= last_sample_s;
            if (last_sample_s) begin
                word_cnt_r   <= {WCW{1'b0}};
                sample_cnt_r <= {SCW{1'b0}};
            end else begin
                if (wr_accept_s) begin
                    word_cnt_r <= word_cnt_r + WCW'(1);
                end
                if (accept_s) begin
                    sample_cnt_r <= sample_cnt_r + SCW'(1);
                end
            end
        end
    end

    // Unpack register: loads a FIFO word, shifts one sample out per acceptance.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= {INPUT_WIDTH{1'b0}};
            idx_r   <= 2'd0;
            vld_r   <= 1'b0;
        end else if (fifo_valid_s) begin
            shift_r <= fifo_rd_data_s;
            idx_r   <= 2'd0;
            vld_r   <= 1'b1;
        end else if (accept_s) begin
            if (idx_r == 2'd2) begin
                idx_r <= 2'd0;
                vld_r <= 1'b0;
            end else begin
                shift_r <= shift_r << NPU_INPUT_WIDTH;
                idx_r   <= idx_r + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_gpio_input_interface.sv
// Scoreboard bench for gpio_input_interface: host writes push expected samples,
// a negedge monitor pops them on every accepted sample and checks event timing.
module tb_gpio_input_interface;

    localparam int BATCH = 42;
    localparam int WPB   = BATCH / 3;

    logic        sys_clk;
    logic        rst_n;
    logic        host_wr_en;
    logic [47:0] host_wr_data;
    logic        host_busy;
    logic        wr_err;
    logic        cal_start;
    logic [15:0] npu_in_data;
    logic        npu_in_data_vld;
    logic        npu_in_ready;
    logic        batch_done;

    gpio_input_interface dut (
        .sys_clk         (sys_clk),
        .rst_n           (rst_n),
        .host_wr_en      (host_wr_en),
        .host_wr_data    (host_wr_data),
        .host_busy       (host_busy),
        .wr_err          (wr_err),
        .cal_start       (cal_start),
        .npu_in_data     (npu_in_data),
        .npu_in_data_vld (npu_in_data_vld),
        .npu_in_ready    (npu_in_ready),
        .batch_done      (batch_done)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] exp_q [$];
    logic [47:0] words [WPB];
    int          batch_wc = 0;
    int          exp_batches = 0;
    int          exp_drop = 0;
    int          exp_cal_cyc = -10;
    int          done_exp = -10;
    int          bubble_cyc = -10;
    int          vld_rise = -10;
    int          samples_seen = 0;
    int          pos = 0;
    int          cal_cnt = 0;
    int          err_cnt = 0;
    int          done_seen = 0;
    bit          mon_en = 1'b0;
    bit          hold_pending = 1'b0;
    logic [15:0] hold_data = 16'h0;
    bit          ready_mode = 1'b0;

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        npu_in_ready = 1'b1;
        forever begin
            @(posedge sys_clk);
            #1;
            npu_in_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard: all output checking happens here.
    always @(negedge sys_clk) begin
        if (mon_en) begin
            if (hold_pending) begin
                chk("hold_vld", 64'(npu_in_data_vld), 64'd1);
                chk("hold_data", 64'(npu_in_data), 64'(hold_data));
            end
            hold_pending = npu_in_data_vld && !npu_in_ready;
            hold_data    = npu_in_data;

            if (cyc == exp_cal_cyc) begin
                chk("cal_start", 64'(cal_start), 64'd1);
                chk("busy_rise", 64'(host_busy), 64'd1);
                vld_rise = cyc + 2;
            end else if (cal_start) begin
                chk("cal_start_cycle", 64'(cyc), 64'(exp_cal_cyc));
            end
            if (cal_start) cal_cnt++;
            if (cyc == vld_rise - 1) chk("first_vld_low", 64'(npu_in_data_vld), 64'd0);
            if (cyc == vld_rise) chk("first_vld_high", 64'(npu_in_data_vld), 64'd1);
            if (cyc == bubble_cyc + 1) chk("bubble_low", 64'(npu_in_data_vld), 64'd0);
            if (cyc == bubble_cyc + 2) chk("bubble_next_vld", 64'(npu_in_data_vld), 64'd1);

            if (cyc == done_exp) begin
                chk("batch_done", 64'(batch_done), 64'd1);
                chk("busy_fall", 64'(host_busy), 64'd0);
                chk("queue_residual", 64'(exp_q.size()), 64'(batch_wc * 3));
                chk("fifo_empty_at_done", 64'(dut.fifo_empty_s), 64'd1);
                if (batch_done) done_seen++;
                done_exp     = -10;
                samples_seen = 0;
                pos          = 0;
            end else if (batch_done) begin
                chk("batch_done_cycle", 64'(cyc), 64'(done_exp));
            end

            if (wr_err) err_cnt++;

            if (npu_in_data_vld && npu_in_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sample_underflow", 64'(exp_q.size()), 64'd1);
                end else begin
                    chk("sample_data", 64'(npu_in_data), 64'(exp_q.pop_front()));
                end
                samples_seen++;
                pos = (pos + 1) % 3;
                if (samples_seen == BATCH) begin
                    done_exp = cyc + 1;
                end else if (pos == 0) begin
                    bubble_cyc = cyc;
                end
            end
        end
    end

    task automatic write_words(input int n);
        for (int i = 0; i < n; i++) begin
            host_wr_en   = 1'b1;
            host_wr_data = words[i];
            for (int j = 0; j < 3; j++) exp_q.push_back(16'(words[i] >> (16 * (2 - j))));
            batch_wc++;
            if (batch_wc == WPB) begin
                exp_cal_cyc = cyc + 1;
                batch_wc    = 0;
                exp_batches++;
            end
            @(posedge sys_clk);
            #1;
        end
        host_wr_en = 1'b0;
    endtask

    task automatic drop_write(input logic [47:0] d);
        host_wr_en   = 1'b1;
        host_wr_data = d;
        exp_drop++;
        @(posedge sys_clk);
        #1;
        host_wr_en = 1'b0;
    endtask

    task automatic rand_words();
        for (int k = 0; k < WPB; k++)
            words[k] = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                        16'($urandom_range(0, 65535))};
    endtask

    task automatic wait_done(input int budget);
        int start;
        bit ok;
        start = done_seen;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge sys_clk);
            #1;
            ok = (done_seen > start);
        end
        if (!ok) chk("done_timeout", 64'(done_seen), 64'(start + 1));
    endtask

    task automatic wait_samples(input int n, input int budget);
        for (int i = 0; i < budget && samples_seen < n; i++) begin
            @(posedge sys_clk);
            #1;
        end
        if (samples_seen < n) chk("samples_timeout", 64'(samples_seen), 64'(n));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst_n        = 1'b0;
        host_wr_en   = 1'b0;
        host_wr_data = 48'h0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_busy", 64'(host_busy), 64'd0);
        chk("rst_wr_err", 64'(wr_err), 64'd0);
        chk("rst_cal", 64'(cal_start), 64'd0);
        chk("rst_data", 64'(npu_in_data), 64'd0);
        chk("rst_vld", 64'(npu_in_data_vld), 64'd0);
        chk("rst_done", 64'(batch_done), 64'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge sys_clk);
        #1;

        // Full batch with ready held high, counting pattern
        for (int k = 0; k < WPB; k++)
            words[k] = {16'(3 * k), 16'(3 * k + 1), 16'(3 * k + 2)};
        write_words(WPB);
        wait_done(300);

        // Backpressure
        ready_mode = 1'b1;
        rand_words();
        write_words(WPB);
        wait_done(600);

        // Write during STREAM is dropped
        rand_words();
        write_words(WPB);
        wait_samples(10, 300);
        drop_write(48'hDEADBEEF0001);
        wait_done(600);
        chk("wr_err_after_stream_write", 64'(err_cnt), 64'(exp_drop));

        // Back-to-back: next batch starts in the batch_done cycle
        ready_mode = 1'b0;
        rand_words();
        write_words(WPB);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (batch_done) found = 1'b1;
            else begin
                @(posedge sys_clk);
                #1;
            end
        end
        if (!found) chk("b2b_done_timeout", 64'(found), 64'd1);
        rand_words();
        write_words(WPB);
        // Write coinciding with the final accepted sample is dropped
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (npu_in_data_vld && npu_in_ready && samples_seen == BATCH - 1) found = 1'b1;
            else begin
                @(posedge sys_clk);
                #1;
            end
        end
        if (!found) chk("last_accept_timeout", 64'(found), 64'd1);
        drop_write(48'h123456789ABC);
        wait_done(300);
        repeat (3) @(posedge sys_clk);
        #1;
        chk("wr_err_last_sample", 64'(err_cnt), 64'(exp_drop));

        // Reset mid-stream
        ready_mode = 1'b1;
        rand_words();
        write_words(WPB);
        wait_samples(20, 600);
        rst_n  = 1'b0;
        mon_en = 1'b0;
        #1;
        chk("midrst_busy", 64'(host_busy), 64'd0);
        chk("midrst_vld", 64'(npu_in_data_vld), 64'd0);
        chk("midrst_data", 64'(npu_in_data), 64'd0);
        chk("midrst_cal", 64'(cal_start), 64'd0);
        chk("midrst_done", 64'(batch_done), 64'd0);
        chk("midrst_wr_err", 64'(wr_err), 64'd0);
        exp_q.delete();
        batch_wc     = 0;
        samples_seen = 0;
        pos          = 0;
        done_exp     = -10;
        bubble_cyc   = -10;
        vld_rise     = -10;
        exp_cal_cyc  = -10;
        hold_pending = 1'b0;
        @(posedge sys_clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge sys_clk);
        #1;
        rand_words();
        write_words(WPB);
        wait_done(600);

        // Partial load: 13 words must not start a batch
        ready_mode = 1'b0;
        rand_words();
        write_words(WPB - 1);
        repeat (10) @(posedge sys_clk);
        #1;
        chk("partial_busy", 64'(host_busy), 64'd0);
        chk("partial_cal_count", 64'(cal_cnt), 64'(exp_batches));
        words[0] = words[WPB - 1];
        write_words(1);
        wait_done(300);

        repeat (3) @(posedge sys_clk);
        #1;
        chk("cal_count", 64'(cal_cnt), 64'(exp_batches));
        chk("wr_err_count", 64'(err_cnt), 64'(exp_drop));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_input_interface.md
# gpio_input_interface

Host-to-NPU ingress block: accepts one batch of 48-bit words from the GPIO host port and buffers them in a FIFO. Once the batch is complete, it pulses `cal_start` and unpacks each word into three 16-bit samples, streamed to the NPU input with a valid/ready handshake. It mirrors the egress packer, which packs NPU outputs 3-per-word, so word/sample ordering is identical in both directions.

## Interface
- `BATCH_NUM`, 42: samples per batch. Must be divisible by 3.
- `NPU_INPUT_WIDTH`, 16: sample width.
- `INPUT_WIDTH`, 48: host word width. Must equal 3×`NPU_INPUT_WIDTH`.
- `FIFO_WIDTH`, 48: FIFO word width. Must equal `INPUT_WIDTH`.
- `FIFO_DEPTH`, 16: FIFO depth. Must be ≥ `BATCH_NUM`/3.
- `sys_clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `host_wr_en`  in  1  host word strobe, one word per cycle high.
- `host_wr_data`  in  `INPUT_WIDTH`  host word.
- `host_busy`  out  1  high while the block is streaming; host writes are not accepted.
- `wr_err`  out  1  one-cycle pulse when a host write is dropped.
- `cal_start`  out  1  one-cycle pulse, NPU batch start.
- `npu_in_data`  out  `NPU_INPUT_WIDTH`  sample to NPU.
- `npu_in_data_vld`  out  1  sample valid.
- `npu_in_ready`  in  1  NPU accepts the sample when both `npu_in_data_vld` and `npu_in_ready` are high.
- `batch_done`  out  1  one-cycle pulse after the last sample is accepted.

## Operation
- Reset values: all outputs 0. Word count, sample count, state and FIFO are cleared.
- Reset mid-operation: the partial batch is discarded and the block returns to IDLE.
- One-hot FSM states: IDLE, LOAD, STREAM.
- **IDLE**
  - `host_wr_en` writes the word into the FIFO, sets word_cnt=1 and moves to LOAD.
  - If `BATCH_NUM`/3 == 1, it moves directly to STREAM.
- **LOAD**
  - Each `host_wr_en` writes one word and increments word_cnt.
  - When the write makes word_cnt == `BATCH_NUM`/3, the next state is STREAM.
- **STREAM**
  - Host writes are dropped and pulse `wr_err`. FIFO contents are unchanged.
  - Unpack order is MSB first: bits [47:32], then [31:16], then [15:0].
  - `npu_in_data` holds its value while vld=1 and ready=0.
  - sample_cnt increments on every accepted sample.
  - When sample `BATCH_NUM` is accepted, `batch_done` pulses the next cycle and the state returns to IDLE with counters cleared.
- A write while the FIFO is full is dropped and pulses `wr_err`. This is unreachable under the parameter constraints but must be handled.
- Sample signedness is not interpreted. Data passes through bit-exact.

## Timing
- The last batch word is written in cycle W. STREAM is entered at T=W+1.
- In cycle T, `cal_start`=1 and `host_busy` rises.
- FIFO `rd_en` is issued in T. `sync_fifo` returns the word at T+1 with `valid`=1.
- The word is loaded into the unpack register at the T+1 edge. `npu_in_data_vld`=1 from T+2.
- Prefetch: `rd_en` for the next word is issued in the cycle the third sample of the current word is accepted.
  - Exactly one bubble cycle follows (vld=0).
  - The next word's first sample is valid two cycles after that acceptance.
- Peak throughput with ready held high: 3 samples per 4 cycles.
- `host_busy` falls in the cycle `batch_done` is high. Host writes are accepted again from that same cycle.
- `host_wr_en` in the same cycle as the final accepted sample is dropped (`wr_err`=1), because the state is still STREAM.

## Structure
- Shared package `gpio_if_pkg`:
  - FSM state encodings IDLE/LOAD/STREAM.
  - `WORDS_PER_BATCH` = `BATCH_NUM`/3.
  - `SAMPLES_PER_WORD` = 3.
  - The egress block uses the same package.
- Sub-module: the existing `sync_fifo` (ports `clk`, `rst_n`, `rd_en`, `wr_en`, `wr_data`, `rd_data`, `valid`, `full`, `empty`), instantiated as `sync_fifo_inst`.
- Unpack shift register and counters are local.
- Counter widths: `$clog2(BATCH_NUM+1)` for the sample count and `$clog2(WORDS_PER_BATCH+1)` for the word count.

## Test plan
- **Full batch, ready high.**
  - Stimulus: 14 words, word k = {3k, 3k+1, 3k+2} in 16-bit fields.
  - Required: `cal_start` at W+1; samples 0..41 in order; one bubble after each third sample; `batch_done` one cycle after sample 41; return to IDLE.
- **Backpressure.**
  - Stimulus: `npu_in_ready` toggles pseudo-randomly.
  - Required: `npu_in_data` is stable while vld=1 and ready=0; no sample is lost or duplicated; sample count is exactly 42.
- **Write during STREAM.**
  - Stimulus: host writes 0xDEADBEEF0001 mid-stream.
  - Required: `wr_err` pulses once; output sequence is unchanged; FIFO is empty at `batch_done`.
- **Back-to-back batches.**
  - Stimulus: the second batch's first write lands in the `batch_done` cycle.
  - Required: the write is accepted; the second `cal_start` follows its 14th word.
- **Reset mid-stream.**
  - Stimulus: `rst_n` pulsed low after 20 samples.
  - Required: all outputs 0 immediately; a fresh batch then produces `cal_start` and 42 correct samples.
- **Partial load.**
  - Stimulus: only 13 words written.
  - Required: no `cal_start`; `host_busy`=0; the 14th word triggers STREAM.
